// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - operand/result handshake bundle for alu_seq_core
interface alu_seq_core_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered ALU with valid/ready handshake and shift-add multiplier
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_core_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_ADC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  localparam int MSB = WIDTH - 1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic                 cin_q, cin_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;

  logic                 in_ready;
  logic                 accept;
  logic                 hi_nz;
  logic [2*WIDTH-1:0]   acc_next;

  logic [SHW-1:0]       amt;
  logic                 cin_use;
  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       dif_ext;
  logic [WIDTH:0]       shl_ext;
  logic [WIDTH:0]       shr_ext;
  logic [WIDTH:0]       sar_ext;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  // Shifts run one bit wider so the last bit shifted out lands in the extra
  // position; an amount of zero naturally leaves that position clear.
  always_comb begin
    amt     = bus.b[SHW-1:0];
    cin_use = (bus.op == OP_ADC) ? cin_q : 1'b0;
    sum_ext = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin_use};
    dif_ext = {1'b0, bus.a} - {1'b0, bus.b};
    shl_ext = {1'b0, bus.a} << amt;
    shr_ext = {bus.a, 1'b0} >> amt;
    sar_ext = $unsigned($signed({bus.a, 1'b0}) >>> amt);

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.a[MSB] == bus.b[MSB]) && (sum_ext[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = (bus.op == OP_CMP) ? bus.a : dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (bus.a[MSB] != bus.b[MSB]) && (dif_ext[MSB] != bus.a[MSB]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_SAR: begin
        alu_res = sar_ext[WIDTH:1];
        alu_c   = sar_ext[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    in_ready = 1'b0;
    hi_nz    = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          hi_nz    = |acc_next[2*WIDTH-1:WIDTH];
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = acc_next[WIDTH-1:0];
          flags_d  = {hi_nz, acc_next[MSB], (acc_next[WIDTH-1:0] == '0), hi_nz};
          cin_d    = hi_nz;
        end
      end
      ST_DONE: begin
        in_ready = bus.out_ready;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept = bus.in_valid & in_ready;
    if (accept) begin
      if (bus.op == OP_MUL) begin
        state_d  = ST_MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, bus.a};
        mplier_d = bus.b;
      end else begin
        state_d  = ST_DONE;
        result_d = alu_res;
        flags_d  = {alu_v, alu_res[MSB], (alu_res == '0), alu_c};
        cin_d    = alu_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_MUL);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - vector table, corner sequences and random model check for alu_seq_core
module tb_alu_seq_core;
  localparam int W = 8;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic tcin;
  vec_t vecs[20];

  alu_seq_core_if #(.WIDTH(W)) bus ();
  alu_seq_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference computed from the opcode definitions with plain integer arithmetic
  function automatic logic [11:0] model(input logic [3:0] op, input int a, input int b, input int c);
    int r, cf, vf, sa, sb, amt, p, s;
    logic [7:0] r8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    amt = b % 8;
    r = 0; cf = 0; vf = 0;
    case (op)
      4'd0, 4'd10: begin
        p  = a + b + ((op == 4'd10) ? c : 0);
        s  = sa + sb + ((op == 4'd10) ? c : 0);
        r  = p % 256;
        cf = (p > 255) ? 1 : 0;
        vf = (s > 127 || s < -128) ? 1 : 0;
      end
      4'd1, 4'd11: begin
        s  = sa - sb;
        r  = (op == 4'd11) ? a : (a - b + 256) % 256;
        cf = (a < b) ? 1 : 0;
        vf = (s > 127 || s < -128) ? 1 : 0;
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = 255 - a;
      4'd6: begin
        r  = (a * (1 << amt)) % 256;
        cf = (amt == 0) ? 0 : (a >> (8 - amt)) % 2;
      end
      4'd7: begin
        r  = a >> amt;
        cf = (amt == 0) ? 0 : (a >> (amt - 1)) % 2;
      end
      4'd8: begin
        r  = (sa >>> amt) & 255;
        cf = (amt == 0) ? 0 : (a >> (amt - 1)) % 2;
      end
      4'd9: begin
        p  = a * b;
        r  = p % 256;
        cf = (p > 255) ? 1 : 0;
        vf = cf;
      end
      default: r = 0;
    endcase
    r8 = 8'(r);
    return {r8, 1'(vf), r8[7], (r8 == 8'd0), 1'(cf)};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [3:0] ef, input string nm);
    int n, lat, nb, bad;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    lat = 1; nb = 0; bad = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) nb++;
      if (bus.busy && bus.in_ready) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, lat, (op == 4'd9) ? 9 : 1);
    check({nm, " busy_cycles"}, nb, (op == 4'd9) ? 8 : 0);
    check({nm, " in_ready_while_busy"}, bad, 0);
    check({nm, " result"}, bus.result, er);
    check({nm, " flags"}, bus.flags, ef);
    tcin = ef[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold_bad, ov_seen;
    logic [11:0] m;

    // flags are {V,N,Z,C}
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[1]  = '{4'd10, 8'h10, 8'h20, 8'h31, 4'b0000};
    vecs[2]  = '{4'd0,  8'h01, 8'h01, 8'h02, 4'b0000};
    vecs[3]  = '{4'd10, 8'h10, 8'h20, 8'h30, 4'b0000};
    vecs[4]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000};
    vecs[5]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0101};
    vecs[6]  = '{4'd10, 8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[7]  = '{4'd9,  8'h10, 8'h11, 8'h10, 4'b1001};
    vecs[8]  = '{4'd9,  8'h03, 8'h05, 8'h0F, 4'b0000};
    vecs[9]  = '{4'd6,  8'h81, 8'h09, 8'h02, 4'b0001};
    vecs[10] = '{4'd8,  8'h80, 8'h03, 8'hF0, 4'b0100};
    vecs[11] = '{4'd7,  8'hA5, 8'h00, 8'hA5, 4'b0100};
    vecs[12] = '{4'd7,  8'h81, 8'h01, 8'h40, 4'b0001};
    vecs[13] = '{4'd11, 8'h05, 8'h07, 8'h05, 4'b0001};
    vecs[14] = '{4'd13, 8'h12, 8'h34, 8'h00, 4'b0010};
    vecs[15] = '{4'd5,  8'h0F, 8'h00, 8'hF0, 4'b0100};
    vecs[16] = '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[17] = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0100};
    vecs[18] = '{4'd4,  8'hAA, 8'hAA, 8'h00, 4'b0010};
    vecs[19] = '{4'd7,  8'h3C, 8'h08, 8'h3C, 4'b0000};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.a = 8'd0; bus.b = 8'd0; bus.out_ready = 1'b1;
    tcin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset result", bus.result, 0);
    check("reset flags", bus.flags, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, $sformatf("vec%0d", i));

    // Backpressure: result must hold and new work must wait
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_op(4'd0, 8'h12, 8'h34, 8'h46, 4'b0000, "bp_add");
    bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01; bus.in_valid = 1'b1;
    hold_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus.result !== 8'h46 || bus.flags !== 4'b0000 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        hold_bad++;
    end
    check("bp hold_violations", hold_bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp release out_valid", bus.out_valid, 1);
    check("bp release result", bus.result, 8'h02);
    tcin = 1'b0;

    // Reset in the middle of a multiply after leaving cin set
    run_op(4'd1, 8'h00, 8'h01, 8'hFF, 4'b0101, "pre_rst_sub");
    bus.op = 4'd9; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_mul busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_mul rst out_valid", bus.out_valid, 0);
    check("mid_mul rst busy", bus.busy, 0);
    check("mid_mul rst result", bus.result, 0);
    check("mid_mul rst flags", bus.flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tcin = 1'b0;
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen++;
    end
    check("mid_mul no_result", ov_seen, 0);
    run_op(4'd10, 8'h00, 8'h00, 8'h00, 4'b0010, "post_rst_adc");

    // Three back-to-back adds, one result per cycle
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h02; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h0A; bus.b = 8'h14;
    check("b2b0 out_valid", bus.out_valid, 1);
    check("b2b0 result", bus.result, 8'h03);
    @(posedge clk); #1;
    bus.a = 8'h7F; bus.b = 8'h01;
    check("b2b1 out_valid", bus.out_valid, 1);
    check("b2b1 result", bus.result, 8'h1E);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b2 out_valid", bus.out_valid, 1);
    check("b2b2 result", bus.result, 8'h80);
    check("b2b2 flags", bus.flags, 4'b1100);
    tcin = 1'b0;

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0] rop;
      logic [7:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = model(rop, int'(ra), int'(rb), int'(tcin));
      run_op(rop, ra, rb, m[11:4], m[3:0], $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It takes full-width A and B operands through a valid/ready handshake and returns a registered result with C/Z/N/V flags. It adds barrel shifts, arithmetic shift, add-with-carry from a stored carry, compare, and an iterative shift-add multiplier. It sits between the tile's input decode and output mux, and holds its result under downstream backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..32)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept this cycle
op  input  4  opcode (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered result
flags  output  4  {V,N,Z,C}, registered
busy  output  1  high while in MUL state

Behaviour:
- Reset: state=IDLE, result=0, flags=0, stored carry cin=0, out_valid=0, busy=0, multiply counter=0. Reset asserted mid-multiply aborts it; no result is produced.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, busy=1.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept = in_valid & in_ready at a rising edge.
- Single-cycle op accepted: next state is DONE, with result and flags loaded at that edge.
- MUL accepted: go to MUL for exactly WIDTH cycles (one partial-product bit per cycle, LSB of B first), then DONE. out_valid is first seen WIDTH+1 cycles after the accept edge.
- In DONE:
  - out_ready=0: hold result/flags stable.
  - out_ready=1, no accept: go to IDLE.
  - out_ready=1 with accept: back-to-back; load the new op, or go to MUL.
- Opcodes (C/V as listed, otherwise 0):
  - 0 ADD: A+B. C=carry out; V=signed overflow.
  - 1 SUB: A-B. C=borrow (A<B unsigned); V=signed overflow.
  - 2 AND; 3 OR; 4 XOR: bitwise A op B.
  - 5 NOT: ~A.
  - 6 SHL, 7 SHR (logical), 8 SAR (arithmetic): A shifted by B[SHW-1:0], i.e. B mod WIDTH. C=last bit shifted out, C=0 if amount=0.
  - 9 MUL: low WIDTH bits of the unsigned A*B. C=V=1 if the high WIDTH bits are nonzero.
  - 10 ADC: A+B+cin. Flags as ADD.
  - 11 CMP: result=A, flags as SUB(A,B).
  - 12-15 reserved: result=0, C=V=0, Z=1.
- Z=(result==0) and N=result[WIDTH-1] for all ops.
- cin is updated to the C flag at every DONE load, including on reserved ops.
- Operands are captured at accept; a/b/op changes afterwards have no effect.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> out_valid one cycle after accept; result=0x00, flags C=1 Z=1 N=0 V=0.
- SUB a=0x80 b=0x01 -> result=0x7F, V=1 C=0 N=0; SUB a=0x00 b=0x01 -> 0xFF, C=1 N=1.
- ADC after the 0xFF+0x01 ADD, a=0x10 b=0x20 -> 0x31; a following ADD 0x01+0x01 clears cin (C=0).
- MUL a=0x10 b=0x11 -> busy for 8 cycles, in_ready=0; out_valid at accept+9; result=0x10, C=V=1. MUL a=3 b=5 -> 0x0F, C=0.
- Shifts: SHL a=0x81 b=0x09 -> amount 1, result 0x02, C=1; SAR a=0x80 b=3 -> 0xF0, C=0; SHR b=0 -> result=a, C=0.
- Backpressure: hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Assert rst during MUL cycle 4 -> all outputs 0 next cycle, no out_valid. Back-to-back: 3 ADDs with in_valid=out_ready=1 -> one result per cycle.
